// File: rtl/icache_pkg.sv
// Shared defines for the instruction cache.
// Bus widths, geometry defaults, field positions, states.
package icache_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam int ICACHE_ENTRIES = 256;
  localparam int ICACHE_TAG_W   = 8;
  localparam int ICACHE_IDX_LSB = 2;
  localparam int ICACHE_IDX_W   = $clog2(ICACHE_ENTRIES);
  localparam int ICACHE_TAG_LSB = ICACHE_IDX_LSB + ICACHE_IDX_W;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag+data line storage for the instruction cache.
// Synchronous write, asynchronous read, no reset.
module icache_ram #(
  parameter int ENTRIES = 256,
  parameter int WIDTH   = 40
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(ENTRIES)-1:0] waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(ENTRIES)-1:0] raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  // line write on fill
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache
// between the IF stage and the memory controller.
module icache
  import icache_pkg::*;
#(
  parameter int ENTRIES = ICACHE_ENTRIES,
  parameter int TAG_W   = ICACHE_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   if_req,
  input  logic [InstAddrBus-1:0] if_addr,
  output logic                   if_done,
  output logic [InstBus-1:0]     if_inst,
  output logic [InstAddrBus-1:0] if_pc,
  output logic                   mc_req,
  output logic [InstAddrBus-1:0] mc_addr,
  input  logic                   mc_done,
  input  logic [InstBus-1:0]     mc_inst,
  input  logic [InstAddrBus-1:0] mc_pc
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_LSB = ICACHE_IDX_LSB + IDX_W;
  localparam int TAG_MSB = TAG_LSB + TAG_W - 1;
  localparam int LINE_W  = TAG_W + InstBus;

  ic_state_e state_q, state_d;
  logic [ENTRIES-1:0] valid_q;

  logic                   done_q, done_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic                   mreq_q, mreq_d;
  logic [InstAddrBus-1:0] maddr_q, maddr_d;

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic [LINE_W-1:0] rdata;
  logic [TAG_W-1:0]  line_tag;
  logic [InstBus-1:0] line_inst;
  logic hit, fill, we;

  logic unused_addr;
  assign unused_addr = ^{if_addr[ICACHE_IDX_LSB-1:0],
                         if_addr[InstAddrBus-1:TAG_MSB+1]};

  assign rd_idx = if_addr[TAG_LSB-1:ICACHE_IDX_LSB];
  assign rd_tag = if_addr[TAG_MSB:TAG_LSB];
  assign wr_idx = maddr_q[TAG_LSB-1:ICACHE_IDX_LSB];
  assign wr_tag = maddr_q[TAG_MSB:TAG_LSB];

  assign line_tag  = rdata[LINE_W-1:InstBus];
  assign line_inst = rdata[InstBus-1:0];

  assign hit  = valid_q[rd_idx] && (line_tag == rd_tag);
  assign fill = (state_q == IC_MISS) && mc_done
             && (mc_pc == maddr_q);
  assign we   = rdy && fill;

  icache_ram #(
    .ENTRIES(ENTRIES),
    .WIDTH  (LINE_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wr_idx),
    .wdata_i({wr_tag, mc_inst}),
    .raddr_i(rd_idx),
    .rdata_o(rdata)
  );

  // hit/miss decision and fill completion
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    mreq_d  = mreq_q;
    maddr_d = maddr_q;
    if (rdy) begin
      done_d = 1'b0;
      unique case (state_q)
        IC_IDLE: begin
          if (if_req) begin
            if (hit) begin
              done_d = 1'b1;
              inst_d = line_inst;
              pc_d   = if_addr;
            end else begin
              maddr_d = if_addr;
              mreq_d  = 1'b1;
              state_d = IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (fill) begin
            mreq_d  = 1'b0;
            state_d = IC_IDLE;
            if (if_req && (if_addr == maddr_q)) begin
              done_d = 1'b1;
              inst_d = mc_inst;
              pc_d   = mc_pc;
            end
          end
        end
      endcase
    end
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IC_IDLE;
      done_q  <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
    end
  end

  // line valid bits, set on fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  assign if_done = done_q;
  assign if_inst = inst_q;
  assign if_pc   = pc_q;
  assign mc_req  = mreq_q;
  assign mc_addr = maddr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache.
// Inputs driven and outputs sampled 1ns after posedge.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done = 1'b0;
  logic [31:0] mc_inst = '0;
  logic [31:0] mc_pc = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rdy    (rdy),
    .if_req (if_req),
    .if_addr(if_addr),
    .if_done(if_done),
    .if_inst(if_inst),
    .if_pc  (if_pc),
    .mc_req (mc_req),
    .mc_addr(mc_addr),
    .mc_done(mc_done),
    .mc_inst(mc_inst),
    .mc_pc  (mc_pc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic mem(input logic v,
                     input logic [31:0] pc,
                     input logic [31:0] inst);
    mc_done = v;
    mc_pc   = pc;
    mc_inst = inst;
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_done", 32'(if_done), 32'd0);
    check("rst_mreq", 32'(mc_req), 32'd0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_maddr", mc_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // cold miss on 0x0 and fill
    fetch(32'h0);
    step();
    check("m0_req", 32'(mc_req), 32'd1);
    check("m0_addr", mc_addr, 32'h0);
    check("m0_done", 32'(if_done), 32'd0);
    step();
    check("m0_wait", 32'(mc_req), 32'd1);
    mem(1'b1, 32'h0, 32'h0000_0013);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("f0_done", 32'(if_done), 32'd1);
    check("f0_inst", if_inst, 32'h0000_0013);
    check("f0_pc", if_pc, 32'h0);
    check("f0_mreq", 32'(mc_req), 32'd0);

    // fill 0x4
    fetch(32'h4);
    step();
    check("m4_addr", mc_addr, 32'h4);
    mem(1'b1, 32'h4, 32'h0010_0093);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("f4_done", 32'(if_done), 32'd1);
    check("f4_inst", if_inst, 32'h0010_0093);

    // back-to-back hits 0x0, 0x4, 0x0
    fetch(32'h0);
    step();
    check("h0_done", 32'(if_done), 32'd1);
    check("h0_inst", if_inst, 32'h0000_0013);
    check("h0_mreq", 32'(mc_req), 32'd0);
    fetch(32'h4);
    step();
    check("h4_done", 32'(if_done), 32'd1);
    check("h4_pc", if_pc, 32'h4);
    check("h4_mreq", 32'(mc_req), 32'd0);
    fetch(32'h0);
    step();
    check("h0b_done", 32'(if_done), 32'd1);
    check("h0b_pc", if_pc, 32'h0);
    if_req = 1'b0;
    step();
    check("idle_done", 32'(if_done), 32'd0);
    check("idle_mreq", 32'(mc_req), 32'd0);

    // conflict 0x400 evicts 0x0
    fetch(32'h400);
    step();
    check("c4_mreq", 32'(mc_req), 32'd1);
    check("c4_addr", mc_addr, 32'h400);
    mem(1'b1, 32'h400, 32'hAAAA_0001);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("c4_inst", if_inst, 32'hAAAA_0001);
    fetch(32'h0);
    step();
    check("c0_mreq", 32'(mc_req), 32'd1);
    check("c0_done", 32'(if_done), 32'd0);
    mem(1'b1, 32'h0, 32'h0000_0013);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("c0_fill", 32'(if_done), 32'd1);

    // wrong-pc fill ignored, pause, jump
    fetch(32'h100);
    step();
    check("j_addr", mc_addr, 32'h100);
    mem(1'b1, 32'h104, 32'hDEAD_0000);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("wpc_mreq", 32'(mc_req), 32'd1);
    check("wpc_done", 32'(if_done), 32'd0);
    rdy = 1'b0;
    mem(1'b1, 32'h100, 32'hDEAD_0001);
    step();
    step();
    mem(1'b0, 32'h0, 32'h0);
    rdy = 1'b1;
    check("p_mreq", 32'(mc_req), 32'd1);
    check("p_addr", mc_addr, 32'h100);
    check("p_done", 32'(if_done), 32'd0);
    fetch(32'h200);
    step();
    check("j_hold", mc_addr, 32'h100);
    mem(1'b1, 32'h100, 32'hBBBB_0002);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("j_nodone", 32'(if_done), 32'd0);
    check("j_drop", 32'(mc_req), 32'd0);
    step();
    check("j2_mreq", 32'(mc_req), 32'd1);
    check("j2_addr", mc_addr, 32'h200);
    mem(1'b1, 32'h200, 32'hCCCC_0003);
    step();
    mem(1'b0, 32'h0, 32'h0);
    check("j2_done", 32'(if_done), 32'd1);
    check("j2_pc", if_pc, 32'h200);
    fetch(32'h100);
    step();
    check("j1_done", 32'(if_done), 32'd1);
    check("j1_inst", if_inst, 32'hBBBB_0002);
    rdy = 1'b0;
    step();
    check("rdy_hold", 32'(if_done), 32'd1);
    rdy = 1'b1;
    if_req = 1'b0;
    step();
    check("rdy_rel", 32'(if_done), 32'd0);

    // reset during miss
    fetch(32'h300);
    step();
    check("r_mreq", 32'(mc_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("r_async", 32'(mc_req), 32'd0);
    mem(1'b1, 32'h300, 32'h1111_1111);
    step();
    mem(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    fetch(32'h0);
    step();
    check("r_miss", 32'(mc_req), 32'd1);
    check("r_done", 32'(if_done), 32'd0);
    check("r_addr", mc_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
